ysyx_25010008_lsu: RTL and testbench
====================================

// Module: ysyx_25010008_lsu
// PURPOSE
//  Load/store unit bus front-end. Takes one load/store request at a time from the EXU.
//  Drives it as an AXI4-Lite master into arbiter port 1. Port 1 is the data port and
//  reaches both the CLINT and the external bus.
//  Performs byte-lane alignment (wstrb/wdata shift), load extraction and sign/zero extension.
//  Returns one response per request to the WBU.
// PARAMETERS
//  ADDR_WIDTH     32  address width; data width is fixed at 32
//  MISALIGN_TRAP  1   1: misaligned request -> error response, no bus access
//                     0: address aligned down and forwarded
// PORTS
//  clock        in   1   sole clock; all state updates on posedge
//  reset        in   1   synchronous, active-low (0 = reset)
//  req_valid    in   1   EXU request valid
//  req_ready    out  1   high only in IDLE
//  req_wen      in   1   1 store, 0 load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-justified
//  req_size     in   2   0 byte, 1 half, 2 word; 3 treated as word
//  req_unsigned in   1   zero-extend load when 1
//  resp_valid   out  1   response valid
//  resp_ready   in   1   WBU accepts response
//  resp_rdata   out  32  extended load data; 0 for stores and errors
//  resp_err     out  1   misaligned access, or bus rresp/bresp != 0
//  araddr/arvalid/arready, rready/rdata/rresp/rvalid          AXI4-Lite read channels (32b data)
//  awaddr/awvalid/awready, wdata/wstrb/wvalid/wready,
//  bready/bresp/bvalid                                        AXI4-Lite write channels
// BEHAVIOUR
//  FSM: IDLE, AR, R, W (AW+W), B, RESP. Every output is registered or decoded from state.
//  Reset (reset==0 at posedge): state=IDLE; all valid/ready outputs 0; all data/addr outputs 0.
//   Reset mid-transaction abandons the transaction; the whole SoC resets together.
//  IDLE: req_ready=1. On req_valid:
//   - latch addr/wdata/size/wen/unsigned;
//   - misaligned (half & a[0], or word & a[1:0]!=0) with MISALIGN_TRAP=1 -> RESP with err=1;
//   - else load -> AR, store -> W.
//  AR: arvalid=1, araddr=latched addr, unmodified (the arbiter decodes the full CLINT
//   address). arvalid is held until arready. Handshake cycle -> R.
//  R: rready=1. On rvalid: sh = rdata >> (8*a[1:0]); extend per size/unsigned;
//   err = (rresp!=0); -> RESP.
//  W: awvalid and wvalid both asserted on entry.
//   - each deasserts independently after its own handshake;
//   - both done (including same cycle) -> B;
//   - wdata = req_wdata << (8*a[1:0]); wstrb = {1,3,F}[size] << a[1:0].
//  B: bready=1. On bvalid: err = (bresp!=0); -> RESP.
//  RESP: resp_valid=1 with stable rdata/err until resp_ready, then -> IDLE.
//   No new request is accepted in the same cycle (req_ready=0 in RESP).
//  Latency: load with zero-wait slave = 4 cycles from req accept to resp_valid
//   (accept, AR, R, RESP). Misaligned error: resp_valid the cycle after accept.
//  Never more than one outstanding transaction. No valid drops before its handshake.
//   arvalid and awvalid are never high together.
//  MISALIGN_TRAP=0: address forced to a & ~(size mask) before lane logic.
// TESTING
//  lb a=0x8000_0003, slave rdata=0x80FF_FF00 -> resp_rdata=0xFFFF_FF80, err=0
//  lhu a=0x8000_0002, rdata=0xBEEF_1234 -> resp_rdata=0x0000_BEEF; araddr=0x8000_0002
//  sb a=0x1000_0001, wdata=0x0000_00AB -> wdata=0x0000_AB00, wstrb=0x2
//   check awready before wready, and both in the same cycle
//  lw a=0x0200_0048 through arbiter+CLINT -> valid mtime low word, err=0
//  lw a=0x8000_0002 (MISALIGN_TRAP=1) -> no arvalid ever; resp_err=1 next cycle
//  Stalls: arready and rvalid delayed 5 cycles, resp_ready low 3 cycles
//   -> arvalid held, resp stable; reset=0 while in R -> all outputs 0 next cycle

Source files
------------

// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: one EXU request at a time, driven as an AXI4-Lite master.
// Handles byte-lane alignment for stores and extraction/extension for loads.
module ysyx_25010008_lsu #(
   parameter int ADDR_WIDTH    = 32,
   parameter bit MISALIGN_TRAP = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   output logic                  rready,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   output logic                  bready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid
);

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_R, S_W, S_B, S_RESP
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            off_q, off_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;
   logic                  arvalid_q, arvalid_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                  rready_q, rready_d;
   logic                  awvalid_q, awvalid_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                  wvalid_q, wvalid_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  bready_q, bready_d;

   logic [1:0]            lane_mask;
   logic                  misal;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [3:0]            strb_base;
   logic [31:0]           rd_sh;
   logic [31:0]           rd_ext;

   always_comb begin
      unique case (req_size)
         2'd0:    lane_mask = 2'b00;
         2'd1:    lane_mask = 2'b01;
         default: lane_mask = 2'b11;
      endcase
   end

   assign misal = (req_addr[1:0] & lane_mask) != 2'b00;

   // Without trapping, misaligned requests are silently aligned down.
   assign eff_addr = MISALIGN_TRAP ? req_addr
      : (req_addr & ~{{(ADDR_WIDTH-2){1'b0}}, lane_mask});

   always_comb begin
      unique case (req_size)
         2'd0:    strb_base = 4'h1;
         2'd1:    strb_base = 4'h3;
         default: strb_base = 4'hF;
      endcase
   end

   assign rd_sh = rdata >> {off_q, 3'b000};

   always_comb begin
      unique case (size_q)
         2'd0: rd_ext = uns_q ? {24'd0, rd_sh[7:0]}
                              : {{24{rd_sh[7]}}, rd_sh[7:0]};
         2'd1: rd_ext = uns_q ? {16'd0, rd_sh[15:0]}
                              : {{16{rd_sh[15]}}, rd_sh[15:0]};
         default: rd_ext = rd_sh;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      arvalid_d    = arvalid_q;
      araddr_d     = araddr_q;
      rready_d     = rready_q;
      awvalid_d    = awvalid_q;
      awaddr_d     = awaddr_q;
      wvalid_d     = wvalid_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      bready_d     = bready_q;

      unique case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               off_d       = eff_addr[1:0];
               size_d      = req_size;
               uns_d       = req_unsigned;
               if (MISALIGN_TRAP && misal) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
               end else if (!req_wen) begin
                  state_d   = S_AR;
                  arvalid_d = 1'b1;
                  araddr_d  = eff_addr;
               end else begin
                  state_d   = S_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = eff_addr;
                  wdata_d   = req_wdata << {eff_addr[1:0], 3'b000};
                  wstrb_d   = strb_base << eff_addr[1:0];
               end
            end
         end
         S_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (rvalid) begin
               rready_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = rresp != 2'b00;
               resp_rdata_d = (rresp != 2'b00) ? 32'd0 : rd_ext;
               state_d      = S_RESP;
            end
         end
         S_W: begin
            awvalid_d = awvalid_q & ~awready;
            wvalid_d  = wvalid_q & ~wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_B;
            end
         end
         S_B: begin
            if (bvalid) begin
               bready_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = bresp != 2'b00;
               resp_rdata_d = 32'd0;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d      = S_IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         off_q        <= 2'd0;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         awaddr_q     <= '0;
         wvalid_q     <= 1'b0;
         wdata_q      <= 32'd0;
         wstrb_q      <= 4'd0;
         bready_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         arvalid_q    <= arvalid_d;
         araddr_q     <= araddr_d;
         rready_q     <= rready_d;
         awvalid_q    <= awvalid_d;
         awaddr_q     <= awaddr_d;
         wvalid_q     <= wvalid_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         bready_q     <= bready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign arvalid    = arvalid_q;
   assign araddr     = araddr_q;
   assign rready     = rready_q;
   assign awvalid    = awvalid_q;
   assign awaddr     = awaddr_q;
   assign wvalid     = wvalid_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign bready     = bready_q;

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Directed and randomized bench for the LSU; the bench itself plays the
// AXI4-Lite slave and the WBU, and predicts results from byte-level rules.
module tb_ysyx_25010008_lsu;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic        rready;
   logic [31:0] rdata = 32'd0;
   logic [1:0]  rresp = 2'd0;
   logic        rvalid = 1'b0;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b0;
   logic        bready;
   logic [1:0]  bresp = 2'd0;
   logic        bvalid = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   ysyx_25010008_lsu dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rready(rready), .rdata(rdata), .rresp(rresp),
      .rvalid(rvalid),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
      .wready(wready),
      .bready(bready), .bresp(bresp), .bvalid(bvalid)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit is_misal(input logic [31:0] a,
                                   input logic [1:0] s);
      return (int'(a % 4) % nbytes(s)) != 0;
   endfunction

   function automatic logic [31:0] ld_model(input logic [31:0] word,
      input logic [31:0] a, input logic [1:0] s, input logic u);
      int     off = int'(a % 4);
      int     nb  = nbytes(s);
      longint lim;
      longint x;
      x = longint'(word) / (longint'(1) << (8 * off));
      if (nb == 4) return 32'(x);
      lim = longint'(1) << (8 * nb);
      x   = x % lim;
      if (!u && x >= lim / 2) x = x - lim;
      return 32'(x);
   endfunction

   function automatic logic [3:0] strb_model(input logic [31:0] a,
                                             input logic [1:0] s);
      logic [3:0] m = 4'd0;
      int off = int'(a % 4);
      for (int i = 0; i < nbytes(s); i++) m[off + i] = 1'b1;
      return m;
   endfunction

   task automatic resp_phase(input logic [31:0] ed, input logic ee,
                             input int rsd);
      repeat (rsd) begin
         @(negedge clock);
         chk("resp_hold_valid", resp_valid, 1);
         chk("resp_hold_rdata", resp_rdata, ed);
         chk("resp_hold_err", resp_err, ee);
         chk("resp_hold_rdy", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      chk("resp_drop", resp_valid, 0);
      chk("back_idle_rdy", req_ready, 1);
   endtask

   task automatic mis_check;
      chk("mis_resp_valid", resp_valid, 1);
      chk("mis_err", resp_err, 1);
      chk("mis_rdata", resp_rdata, 0);
      chk("mis_no_ar", arvalid, 0);
      chk("mis_no_aw", awvalid, 0);
      chk("mis_no_w", wvalid, 0);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [1:0] s,
      input logic u, input logic [31:0] word, input logic [1:0] rr,
      input int ard, input int rd, input int rsd);
      logic [31:0] ed;
      logic        ee;
      bit          mis = is_misal(a, s);
      ee = mis || (rr != 2'd0);
      ed = ee ? 32'd0 : ld_model(word, a, s, u);
      @(negedge clock);
      chk("ld_req_ready", req_ready, 1);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = a;
      req_size = s; req_unsigned = u; req_wdata = $urandom;
      @(negedge clock);
      req_valid = 1'b0;
      if (mis) begin
         mis_check();
      end else begin
         chk("ld_arvalid", arvalid, 1);
         chk("ld_araddr", araddr, a);
         chk("ld_no_aw", awvalid, 0);
         chk("ld_busy", req_ready, 0);
         repeat (ard) begin
            @(negedge clock);
            chk("ar_held", arvalid, 1);
            chk("ar_addr_held", araddr, a);
         end
         arready = 1'b1;
         @(negedge clock);
         arready = 1'b0;
         chk("ar_dropped", arvalid, 0);
         chk("rready_on", rready, 1);
         repeat (rd) begin
            @(negedge clock);
            chk("r_wait_rready", rready, 1);
            chk("r_wait_novalid", resp_valid, 0);
         end
         rvalid = 1'b1; rdata = word; rresp = rr;
         @(negedge clock);
         rvalid = 1'b0; rdata = $urandom; rresp = 2'd0;
         chk("rready_off", rready, 0);
         chk("ld_resp_valid", resp_valid, 1);
         chk("ld_rdata", resp_rdata, ed);
         chk("ld_err", resp_err, ee);
      end
      resp_phase(ed, ee, rsd);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] s,
      input logic [31:0] wd, input logic [1:0] br,
      input int awd, input int wdd, input int rsd);
      logic ee;
      bit   mis = is_misal(a, s);
      int   n   = (awd > wdd) ? awd : wdd;
      ee = mis || (br != 2'd0);
      @(negedge clock);
      chk("st_req_ready", req_ready, 1);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = a;
      req_size = s; req_unsigned = $urandom; req_wdata = wd;
      @(negedge clock);
      req_valid = 1'b0;
      if (mis) begin
         mis_check();
      end else begin
         chk("st_awvalid", awvalid, 1);
         chk("st_wvalid", wvalid, 1);
         chk("st_no_ar", arvalid, 0);
         chk("st_awaddr", awaddr, a);
         chk("st_wdata", wdata, wd << (8 * int'(a % 4)));
         chk("st_wstrb", {28'd0, wstrb}, {28'd0, strb_model(a, s)});
         for (int c = 0; c <= n; c++) begin
            awready = (c == awd);
            wready  = (c == wdd);
            @(negedge clock);
            awready = 1'b0;
            wready  = 1'b0;
            chk("aw_valid_seq", awvalid, (c < awd) ? 1 : 0);
            chk("w_valid_seq", wvalid, (c < wdd) ? 1 : 0);
            chk("st_ar_never", arvalid, 0);
            chk("bready_seq", bready, (c == n) ? 1 : 0);
         end
         bvalid = 1'b1; bresp = br;
         @(negedge clock);
         bvalid = 1'b0; bresp = 2'd0;
         chk("bready_off", bready, 0);
         chk("st_resp_valid", resp_valid, 1);
         chk("st_rdata", resp_rdata, 0);
         chk("st_err", resp_err, ee);
      end
      resp_phase(32'd0, ee, rsd);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_resp_err"}, resp_err, 0);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_araddr"}, araddr, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_awaddr"}, awaddr, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_wstrb"}, {28'd0, wstrb}, 0);
      chk({tag, "_bready"}, bready, 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  s;

      repeat (3) @(negedge clock);
      all_zero("rst");
      reset = 1'b1;
      @(negedge clock);
      chk("post_rst_ready", req_ready, 1);

      // lb sign-extends the top byte
      do_load(32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FF00, 2'd0, 0, 0, 0);
      chk("lb_const", resp_rdata, 32'hFFFF_FF80);
      do_load(32'h8000_0002, 2'd1, 1'b1, 32'hBEEF_1234, 2'd0, 0, 0, 0);
      chk("lhu_const", resp_rdata, 32'h0000_BEEF);
      do_load(32'h0200_0048, 2'd2, 1'b0, 32'h0001_2345, 2'd0, 1, 1, 0);
      do_load(32'h8000_0002, 2'd2, 1'b0, 32'h1111_1111, 2'd0, 0, 0, 1);
      do_load(32'h8000_0001, 2'd1, 1'b0, 32'h1111_1111, 2'd0, 0, 0, 0);
      do_load(32'h8000_0004, 2'd3, 1'b0, 32'hCAFE_F00D, 2'd0, 0, 0, 0);
      do_load(32'h8000_0000, 2'd1, 1'b0, 32'h0000_8001, 2'd0, 5, 5, 3);
      do_load(32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 2'd2, 0, 2, 1);

      do_store(32'h1000_0001, 2'd0, 32'h0000_00AB, 2'd0, 0, 2, 0);
      do_store(32'h1000_0001, 2'd0, 32'h0000_00AB, 2'd0, 0, 0, 0);
      do_store(32'h1000_0002, 2'd1, 32'h0000_BEEF, 2'd0, 3, 0, 2);
      do_store(32'h1000_0004, 2'd2, 32'hDEAD_BEEF, 2'd3, 1, 1, 0);
      do_store(32'h1000_0003, 2'd1, 32'h0000_BEEF, 2'd0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         s = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0)
            a = a & ~32'(nbytes(s) - 1);
         if ($urandom_range(0, 1) == 0)
            do_load(a, s, 1'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2));
         else
            do_store(a, s, $urandom,
                     ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd0,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2));
      end

      // reset while waiting in the read-data phase
      @(negedge clock);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
      req_size = 2'd2;
      @(negedge clock);
      req_valid = 1'b0;
      arready = 1'b1;
      @(negedge clock);
      arready = 1'b0;
      chk("mid_rready", rready, 1);
      reset = 1'b0;
      @(negedge clock);
      all_zero("mid_rst");
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_ready", req_ready, 1);
      do_load(32'h8000_0010, 2'd0, 1'b1, 32'h0000_00F0, 2'd0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
